tri_point_test_pipe: RTL
========================

// Module: tri_point_test_pipe
// PURPOSE
//   Pipelined point-in-triangle tester. Holds one triangle (3 vertices), streams query points with valid/ready,
//   returns an inside flag per point. Edge-function test is independent of winding (CW or CCW).
//   Edge-inclusion is selectable and a tag travels with each point. Sits between vertex setup and the pixel writer.
// PARAMETERS
//   CW        12  coordinate width, unsigned, all vertex and point coordinates
//   TAG_W     8   width of the per-point tag carried to the result
//   INCLUSIVE 1   1: a point on an edge or vertex is inside; 0: edges are exclusive
//   CNT_W     16  hit counter width (used only with TRI_HIT_COUNT_EN)
// PORTS
//   clk        in   1       clock, all state on rising edge
//   rst_n      in   1       asynchronous reset, active-low
//   tri_load   in   1       load request; vertices are captured when tri_load && tri_ready
//   tri_ready  out  1       1 when no point is in flight and state != LOAD
//   v0x..v2y   in   CW each the three vertices (v0x,v0y,v1x,v1y,v2x,v2y)
//   pt_valid   in   1       query point valid
//   pt_ready   out  1       point accepted when pt_valid && pt_ready
//   pt_x,pt_y  in   CW      query point
//   pt_tag     in   TAG_W   opaque tag
//   res_valid  out  1       result valid; held until res_ready
//   res_ready  in   1       downstream accepts
//   res_inside out  1       1 = point inside the triangle
//   res_tag    out  TAG_W   tag of the point that produced this result
//   degen      out  1       the loaded triangle has zero area
//   hit_count  out  CNT_W   present only with TRI_HIT_COUNT_EN
// BEHAVIOUR
//   Reset: state EMPTY; all stage valids, res_valid, res_inside, res_tag, degen and hit_count are 0.
//   Reset mid-operation discards in-flight points and the triangle.
//   Arithmetic: differences are signed CW+1 bits, products signed 2CW+2 bits, edge values signed 2CW+3 bits.
//     No overflow is possible at these widths.
//   Edge function: E(a,b,p) = (px-bx)*(ay-by) - (ax-bx)*(py-by).
//   FSM:
//     EMPTY -(tri_load)-> LOAD. In LOAD the vertices are registered and O = E(v0,v1,v2) is computed.
//     LOAD -(1 cycle)-> RUN. On leaving LOAD: orient = sign(O), degen = (O==0).
//     RUN -(tri_load && tri_ready)-> LOAD.
//     pt_ready=0 in EMPTY and LOAD.
//   Priority: when tri_load && tri_ready in RUN, the load wins and pt_ready=0 in that cycle.
//   Pipeline: 3 stages.
//     S1: differences. S2: six products. S3: three edges E(v0,v1,p), E(v1,v2,p), E(v2,v0,p) and the compare.
//     res_valid rises 3 cycles after acceptance when there is no backpressure. Throughput is 1 point/clk.
//   Inside rule: every edge Ei satisfies Ei*orient > 0, or >= 0 if INCLUSIVE=1.
//     degen=1 forces res_inside=0 for every point.
//   Backpressure:
//     advance = !res_valid || res_ready. The whole pipeline stalls when advance=0. pt_ready = advance in RUN.
//     res_inside and res_tag stay stable while res_valid && !res_ready.
//   tri_ready = (state==EMPTY || state==RUN) && no stage valid && !res_valid.
//     A new triangle never mixes with old points.
//   Point coordinates are unrestricted: outside the bounding box, 0 and 2^CW-1 are all legal.
// CONFIGURATION
//   TRI_HIT_COUNT_EN defined:
//     hit_count port exists. It increments on each res_valid && res_ready && res_inside and saturates at 2^CW_CNT-1.
//     It is cleared to 0 on a tri_load handshake and on reset.
//   TRI_HIT_COUNT_EN undefined: hit_count port and its logic are absent. All other behaviour is identical.
// TESTING (CW=12, INCLUSIVE=1 unless noted)
//   1 Load (20,20),(40,20),(30,40). Stream (25,25),(18,25),(20,22),(40,22) back to back, res_ready=1.
//     -> res_inside 1,0,0,0 on consecutive cycles, first 3 clk after acceptance, tags in order, degen=0.
//   2 Same triangle loaded in reverse winding (40,20),(20,20),(30,40). Point (25,25) -> 1, point (18,25) -> 0.
//   3 Point (30,20) lies on edge v0-v1. INCLUSIVE=1 -> 1. INCLUSIVE=0 -> 0. Vertex (20,20) behaves the same way.
//   4 Collinear triangle (0,0),(10,10),(20,20): degen=1 and point (10,10) -> 0.
//     Extremes (4095,4095) with (0,0),(4095,0),(0,4095) -> correct, no overflow.
//   5 Hold res_ready=0 for 5 cycles while pt_valid=1.
//     -> pt_ready drops, the result is held, no point is lost or duplicated, order is kept.
//     tri_load while points are in flight -> tri_ready=0 until the pipe drains.
//   6 rst_n low mid-stream -> res_valid=0 and state EMPTY; pt_ready=0 until reload.
//     With TRI_HIT_COUNT_EN: hit_count=1 after test 1, and it clears on the next load.

Source files
------------

// File: rtl/tri_point_test_pipe_if.sv
// -----------------------------------------------------------------------------
// tri_point_test_pipe_if
//   Bundles the triangle-load, point-query and result handshakes of the
//   point-in-triangle tester.
//   master : the side that loads triangles, streams points and takes results.
//   slave  : the tester itself.
//   Signals:
//     tri_load/tri_ready       triangle load handshake, vertices v0x..v2y
//     pt_valid/pt_ready        query point handshake, pt_x, pt_y, pt_tag
//     res_valid/res_ready      result handshake, res_inside, res_tag
//     degen                    loaded triangle has zero area
//     hit_count                inside-result counter (only with TRI_HIT_COUNT_EN)
//   Optional feature macro: TRI_HIT_COUNT_EN
// -----------------------------------------------------------------------------
interface tri_point_test_pipe_if #(
    parameter int CW    = 12,
    parameter int TAG_W = 8
`ifdef TRI_HIT_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) ();
    logic             tri_load;
    logic             tri_ready;
    logic [CW-1:0]    v0x, v0y, v1x, v1y, v2x, v2y;
    logic             pt_valid;
    logic             pt_ready;
    logic [CW-1:0]    pt_x, pt_y;
    logic [TAG_W-1:0] pt_tag;
    logic             res_valid;
    logic             res_ready;
    logic             res_inside;
    logic [TAG_W-1:0] res_tag;
    logic             degen;
`ifdef TRI_HIT_COUNT_EN
    logic [CNT_W-1:0] hit_count;
`endif

    modport master (
        output tri_load, v0x, v0y, v1x, v1y, v2x, v2y,
        output pt_valid, pt_x, pt_y, pt_tag, res_ready,
        input  tri_ready, pt_ready, res_valid, res_inside, res_tag, degen
`ifdef TRI_HIT_COUNT_EN
        , input hit_count
`endif
    );

    modport slave (
        input  tri_load, v0x, v0y, v1x, v1y, v2x, v2y,
        input  pt_valid, pt_x, pt_y, pt_tag, res_ready,
        output tri_ready, pt_ready, res_valid, res_inside, res_tag, degen
`ifdef TRI_HIT_COUNT_EN
        , output hit_count
`endif
    );
endinterface

// File: rtl/tri_point_test_pipe.sv
// -----------------------------------------------------------------------------
// tri_point_test_pipe
//   Pipelined point-in-triangle tester. Holds one triangle, accepts one query
//   point per clock and returns an inside flag plus the point's tag three
//   cycles later. Winding-independent: the sign of the triangle's own edge
//   function sets the orientation used for every point.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    tri_point_test_pipe_if.slave (load, point and result handshakes,
//            degen flag, optional hit_count)
//   Parameters: CW coordinate width, TAG_W tag width, INCLUSIVE edge
//   inclusion, CNT_W hit counter width (only with TRI_HIT_COUNT_EN).
//   Optional feature macro: TRI_HIT_COUNT_EN adds the saturating hit counter.
// -----------------------------------------------------------------------------
module tri_point_test_pipe #(
    parameter int CW        = 12,
    parameter int TAG_W     = 8,
    parameter bit INCLUSIVE = 1'b1
`ifdef TRI_HIT_COUNT_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tri_point_test_pipe_if.slave  bus
);
    localparam int DW = CW + 1;        // coordinate difference
    localparam int PW = 2 * CW + 2;    // product of two differences
    localparam int EW = 2 * CW + 3;    // edge value

    typedef logic signed [DW-1:0] diff_t;
    typedef logic signed [PW-1:0] prod_t;
    typedef logic signed [EW-1:0] edge_t;
    typedef enum logic [1:0] {ST_EMPTY, ST_LOAD, ST_RUN} state_e;

    function automatic diff_t sub_c(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic prod_t mul_s(input diff_t a, input diff_t b);
        prod_t ax, bx;
        ax = prod_t'(a);
        bx = prod_t'(b);
        return ax * bx;
    endfunction

    function automatic edge_t sub_p(input prod_t a, input prod_t b);
        return edge_t'(a) - edge_t'(b);
    endfunction

    state_e           state_q, state_d;
    logic             orient_neg_q, degen_q;
    logic             s1_valid_q, s2_valid_q, res_valid_q;
    logic             res_inside_q;
    logic [TAG_W-1:0] res_tag_q;

    logic [CW-1:0]    vx_q [3], vy_q [3];
    logic [CW-1:0]    vin_x [3], vin_y [3];
    diff_t            s1_dpx_q [3], s1_day_q [3], s1_dax_q [3], s1_dpy_q [3];
    prod_t            s2_pa_q [3], s2_pb_q [3];
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q;

    logic  tri_ready, tri_fire, advance, pt_ready, pt_fire, inside_c;
    edge_t orient_c;

    assign vin_x = '{bus.v0x, bus.v1x, bus.v2x};
    assign vin_y = '{bus.v0y, bus.v1y, bus.v2y};

    // A new triangle is only taken with an empty pipe, so old points never see it.
    assign tri_ready = (state_q == ST_EMPTY || state_q == ST_RUN)
                       && !s1_valid_q && !s2_valid_q && !res_valid_q;
    assign tri_fire  = bus.tri_load && tri_ready;
    assign advance   = !res_valid_q || bus.res_ready;
    // A load handshake takes priority over a point in the same cycle.
    assign pt_ready  = (state_q == ST_RUN) && advance && !tri_fire;
    assign pt_fire   = bus.pt_valid && pt_ready;

    // Triangle orientation O = E(v0,v1,v2), evaluated from the captured vertices in LOAD.
    assign orient_c = sub_p(mul_s(sub_c(vx_q[2], vx_q[1]), sub_c(vy_q[0], vy_q[1])),
                            mul_s(sub_c(vx_q[0], vx_q[1]), sub_c(vy_q[2], vy_q[1])));

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (tri_fire) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_RUN;
            ST_RUN:   if (tri_fire) state_d = ST_LOAD;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // S3 compare: each edge must agree with the triangle orientation.
    always_comb begin : compare_blk
        edge_t e;
        logic  neg, zero, ok;
        inside_c = !degen_q;
        for (int k = 0; k < 3; k++) begin
            e    = sub_p(s2_pa_q[k], s2_pb_q[k]);
            neg  = e[EW-1];
            zero = (e == '0);
            ok   = orient_neg_q ? neg : (!neg && !zero);
            inside_c = inside_c && (ok || (INCLUSIVE && zero));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            orient_neg_q <= 1'b0;
            degen_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_inside_q <= 1'b0;
            res_tag_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_LOAD) begin
                orient_neg_q <= orient_c[EW-1];
                degen_q      <= (orient_c == '0);
            end
            if (advance) begin
                s1_valid_q  <= pt_fire;
                s2_valid_q  <= s1_valid_q;
                res_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    res_inside_q <= inside_c;
                    res_tag_q    <= s2_tag_q;
                end
            end
        end
    end

    // NOTE: vertex and datapath registers carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (tri_fire) begin
            for (int k = 0; k < 3; k++) begin
                vx_q[k] <= vin_x[k];
                vy_q[k] <= vin_y[k];
            end
        end
        if (advance) begin
            s1_tag_q <= bus.pt_tag;
            s2_tag_q <= s1_tag_q;
            // Edge k runs from a = v[k] to b = v[k+1 mod 3].
            for (int k = 0; k < 3; k++) begin
                s1_dpx_q[k] <= sub_c(bus.pt_x, vx_q[(k + 1) % 3]);
                s1_day_q[k] <= sub_c(vy_q[k], vy_q[(k + 1) % 3]);
                s1_dax_q[k] <= sub_c(vx_q[k], vx_q[(k + 1) % 3]);
                s1_dpy_q[k] <= sub_c(bus.pt_y, vy_q[(k + 1) % 3]);
                s2_pa_q[k]  <= mul_s(s1_dpx_q[k], s1_day_q[k]);
                s2_pb_q[k]  <= mul_s(s1_dax_q[k], s1_dpy_q[k]);
            end
        end
    end

`ifdef TRI_HIT_COUNT_EN
    logic [CNT_W-1:0] hit_count_q;

    // A load handshake needs an empty pipe, so it never coincides with a counted result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q <= '0;
        end else if (tri_fire) begin
            hit_count_q <= '0;
        end else if (res_valid_q && bus.res_ready && res_inside_q && hit_count_q != '1) begin
            hit_count_q <= hit_count_q + 1'b1;
        end
    end

    assign bus.hit_count = hit_count_q;
`endif

    assign bus.tri_ready  = tri_ready;
    assign bus.pt_ready   = pt_ready;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_inside = res_inside_q;
    assign bus.res_tag    = res_tag_q;
    assign bus.degen      = degen_q;
endmodule
